// File: rtl/int_pkg.sv
// Shared definitions for the 8051 interrupt priority sequencer.
//   - source index constants, vector layout, sequencer state encoding
//   - vec_addr(): vector address of a source index
package int_pkg;

   localparam int unsigned NUM_SRC    = 5;
   localparam int unsigned IDX_W      = 3;
   localparam int unsigned VEC_W      = 16;
   localparam int unsigned VEC_STRIDE = 8;
   localparam logic [VEC_W-1:0] VEC_BASE = 16'h0003;

   localparam logic [IDX_W-1:0] SRC_IE0 = 3'd0;
   localparam logic [IDX_W-1:0] SRC_TF0 = 3'd1;
   localparam logic [IDX_W-1:0] SRC_IE1 = 3'd2;
   localparam logic [IDX_W-1:0] SRC_TF1 = 3'd3;
   localparam logic [IDX_W-1:0] SRC_SER = 3'd4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      CLR  = 2'd2
   } state_t;

   // LCALL target for a source: VEC_BASE + VEC_STRIDE*idx
   function automatic logic [VEC_W-1:0] vec_addr(input logic [IDX_W-1:0] idx);
      return VEC_BASE + VEC_W'(VEC_STRIDE) * VEC_W'(idx);
   endfunction

endpackage

// File: rtl/int_prio_encoder.sv
// Combinational priority resolver for the interrupt sources.
// Ports:
//   i_pending    - masked request flags (flag & enable & EA)
//   i_ip         - per-source priority (1 = high)
//   i_in_service - {high active, low active}
//   o_valid_c    - an eligible source exists
//   o_idx_c      - winning source index
//   o_level_c    - winning source level (1 = high)
module int_prio_encoder
   import int_pkg::*;
(
   input  logic [NUM_SRC-1:0] i_pending,
   input  logic [NUM_SRC-1:0] i_ip,
   input  logic [1:0]         i_in_service,
   output logic               o_valid_c,
   output logic [IDX_W-1:0]   o_idx_c,
   output logic               o_level_c
);

   logic [NUM_SRC-1:0] w_hi;
   logic [NUM_SRC-1:0] w_lo;

   assign w_hi = i_pending & i_ip;
   assign w_lo = i_pending & ~i_ip;

   // Lowest set index gives the fixed natural order within a level
   function automatic logic [IDX_W-1:0] lowest_set(input logic [NUM_SRC-1:0] v);
      logic [IDX_W-1:0] r;
      r = '0;
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
         if (v[i]) r = IDX_W'(i);
      end
      return r;
   endfunction

   // A high service blocks everything; a low service blocks only low sources
   always_comb begin
      o_valid_c = 1'b0;
      o_idx_c   = '0;
      o_level_c = 1'b0;
      if (!i_in_service[1]) begin
         if (w_hi != '0) begin
            o_valid_c = 1'b1;
            o_level_c = 1'b1;
            o_idx_c   = lowest_set(w_hi);
         end else if (!i_in_service[0] && (w_lo != '0)) begin
            o_valid_c = 1'b1;
            o_idx_c   = lowest_set(w_lo);
         end
      end
   end

endmodule

// File: rtl/int_priority_sequencer.sv
// 8051 interrupt service sequencer: polls at instruction boundaries,
// issues a vectored LCALL request with req/ack, tracks two-level nesting
// and strobes hardware flag clears.
// Ports:
//   clk, rst_n   - clock, asynchronous active-low reset
//   ie, ip       - IE SFR (bit 7 = EA), IP SFR bits 4:0
//   src_flag     - raw request flags {RI|TI, TF1, IE1, TF0, IE0}
//   instr_end    - last cycle of an instruction
//   poll_block   - current instruction is RETI or writes IE/IP
//   int_ack      - CPU accepted the presented vector
//   reti         - CPU executed RETI
//   int_req      - request to CPU
//   int_vector   - vector address while int_req
//   clr_flag     - one-cycle flag-clear strobes
//   in_service   - {high active, low active}
//   busy         - sequencer not idle
module int_priority_sequencer
   import int_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic [7:0]         ie,
   input  logic [4:0]         ip,
   input  logic [NUM_SRC-1:0] src_flag,
   input  logic               instr_end,
   input  logic               poll_block,
   input  logic               int_ack,
   input  logic               reti,
   output logic               int_req,
   output logic [VEC_W-1:0]   int_vector,
   output logic [NUM_SRC-1:0] clr_flag,
   output logic [1:0]         in_service,
   output logic               busy
);

   state_t               r_state,   w_state_nxt;
   logic [IDX_W-1:0]     r_idx,     w_idx_nxt;
   logic                 r_level,   w_level_nxt;
   logic                 r_int_req, w_int_req_nxt;
   logic [VEC_W-1:0]     r_vector,  w_vector_nxt;
   logic [NUM_SRC-1:0]   r_clr,     w_clr_nxt;
   logic [1:0]           r_is,      w_is_nxt;
   logic                 r_busy,    w_busy_nxt;

   logic [NUM_SRC-1:0]   w_pending;
   logic                 w_enc_valid;
   logic [IDX_W-1:0]     w_enc_idx;
   logic                 w_enc_level;
   logic                 w_unused_ie;

   assign w_pending   = src_flag & ie[NUM_SRC-1:0] & {NUM_SRC{ie[7]}};
   assign w_unused_ie = ^ie[6:5];

   int_prio_encoder u_enc (
      .i_pending    (w_pending),
      .i_ip         (ip),
      .i_in_service (r_is),
      .o_valid_c    (w_enc_valid),
      .o_idx_c      (w_enc_idx),
      .o_level_c    (w_enc_level)
   );

   // State and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= IDLE;
         r_idx     <= '0;
         r_level   <= 1'b0;
         r_int_req <= 1'b0;
         r_vector  <= '0;
         r_clr     <= '0;
         r_is      <= 2'b00;
         r_busy    <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_idx     <= w_idx_nxt;
         r_level   <= w_level_nxt;
         r_int_req <= w_int_req_nxt;
         r_vector  <= w_vector_nxt;
         r_clr     <= w_clr_nxt;
         r_is      <= w_is_nxt;
         r_busy    <= w_busy_nxt;
      end
   end

   // Next-state and next-output logic
   always_comb begin
      w_state_nxt   = r_state;
      w_idx_nxt     = r_idx;
      w_level_nxt   = r_level;
      w_int_req_nxt = r_int_req;
      w_vector_nxt  = r_vector;
      w_clr_nxt     = '0;
      w_is_nxt      = r_is;

      // RETI retires the highest active level before any same-cycle ack sets a bit
      if (reti) begin
         if (r_is[1]) w_is_nxt[1] = 1'b0;
         else         w_is_nxt[0] = 1'b0;
      end

      unique case (r_state)
         IDLE: begin
            if (instr_end && !poll_block && w_enc_valid) begin
               w_state_nxt   = REQ;
               w_idx_nxt     = w_enc_idx;
               w_level_nxt   = w_enc_level;
               w_int_req_nxt = 1'b1;
               w_vector_nxt  = vec_addr(w_enc_idx);
            end
         end
         // Latched request is committed until acknowledged
         REQ: begin
            if (int_ack) begin
               w_is_nxt[r_level] = 1'b1;
               w_int_req_nxt     = 1'b0;
               w_state_nxt       = CLR;
               // Serial flags are cleared by software only
               if (r_idx <= SRC_TF1) w_clr_nxt[r_idx] = 1'b1;
            end
         end
         CLR:     w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase

      w_busy_nxt = (w_state_nxt != IDLE);
   end

   assign int_req    = r_int_req;
   assign int_vector = r_vector;
   assign clr_flag   = r_clr;
   assign in_service = r_is;
   assign busy       = r_busy;

endmodule

// File: tb/tb_int_priority_sequencer.sv
// Scoreboard bench for int_priority_sequencer: stimulus pushes expected
// grants, a negedge monitor pops and compares as the DUT presents them.
module tb_int_priority_sequencer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [7:0]  ie;
   logic [4:0]  ip;
   logic [4:0]  src_flag;
   logic        instr_end;
   logic        poll_block;
   logic        int_ack;
   logic        reti;
   logic        int_req;
   logic [15:0] int_vector;
   logic [4:0]  clr_flag;
   logic [1:0]  in_service;
   logic        busy;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [15:0] vec;
      logic [4:0]  clr;
   } exp_t;

   exp_t       exp_q[$];
   logic [1:0] m_is   = 2'b00;
   bit         m_req  = 1'b0;
   bit         m_busy = 1'b0;
   logic [4:0] cur_clr = '0;
   bit         prev_ack = 1'b0;
   bit         prev_req = 1'b0;

   int_priority_sequencer dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .ie         (ie),
      .ip         (ip),
      .src_flag   (src_flag),
      .instr_end  (instr_end),
      .poll_block (poll_block),
      .int_ack    (int_ack),
      .reti       (reti),
      .int_req    (int_req),
      .int_vector (int_vector),
      .clr_flag   (clr_flag),
      .in_service (in_service),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: which source wins, straight from the eligibility rules; -1 = none
   function automatic int pick(input logic [7:0] e, input logic [4:0] p,
                               input logic [4:0] f, input logic [1:0] is,
                               output bit lvl);
      lvl = 1'b0;
      if (!e[7] || is[1]) return -1;
      for (int i = 0; i < 5; i++)
         if (f[i] && e[i] && p[i]) begin lvl = 1'b1; return i; end
      if (is[0]) return -1;
      for (int i = 0; i < 5; i++)
         if (f[i] && e[i]) return i;
      return -1;
   endfunction

   // Reference RETI: retire the most recent nesting level
   function automatic logic [1:0] after_reti(input logic [1:0] is);
      case (is)
         2'b11:   return 2'b01;
         2'b10:   return 2'b00;
         2'b01:   return 2'b00;
         default: return 2'b00;
      endcase
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic poll(input logic [7:0] e, input logic [4:0] p, input logic [4:0] f,
                       input bit blk, output bit granted, output bit lvl);
      int idx;
      exp_t t;
      ie = e; ip = p; src_flag = f; poll_block = blk; instr_end = 1'b1;
      idx = pick(e, p, f, m_is, lvl);
      granted = (idx >= 0) && !blk;
      if (granted) begin
         t.vec = 16'(3 + 8 * idx);
         t.clr = (idx <= 3) ? 5'(1 << idx) : 5'b0;
         exp_q.push_back(t);
      end
      tick();
      instr_end = 1'b0; poll_block = 1'b0;
      if (granted) begin
         m_req = 1'b1; m_busy = 1'b1;
         check("req_latency", 32'(int_req), 32'd1);
      end
   endtask

   task automatic ack(input bit lvl, input bit with_reti);
      int_ack = 1'b1; reti = with_reti;
      tick();
      int_ack = 1'b0; reti = 1'b0;
      if (with_reti) m_is = after_reti(m_is);
      m_is[lvl] = 1'b1;
      m_req = 1'b0;
      tick();
      m_busy = 1'b0;
   endtask

   task automatic reti_pulse();
      reti = 1'b1;
      tick();
      reti = 1'b0;
      m_is = after_reti(m_is);
   endtask

   // Monitor: level checks every cycle, vector on each new request, clear strobe after each ack
   always @(negedge clk) begin
      if (!rst_n) begin
         prev_ack = 1'b0;
         prev_req = 1'b0;
      end else begin
         logic [4:0] exp_clr;
         exp_t t;
         check("int_req", 32'(int_req), 32'(m_req));
         check("in_service", 32'(in_service), 32'(m_is));
         check("busy", 32'(busy), 32'(m_busy));
         if (int_req && !prev_req) begin
            if (exp_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_req: vector %0h with no grant expected at %0t", int_vector, $time);
            end else begin
               t = exp_q.pop_front();
               check("int_vector", 32'(int_vector), 32'(t.vec));
               cur_clr = t.clr;
            end
         end
         exp_clr = prev_ack ? cur_clr : 5'b0;
         if (prev_ack || (clr_flag != 5'b0)) check("clr_flag", 32'(clr_flag), 32'(exp_clr));
         prev_ack = int_req && int_ack;
         prev_req = int_req;
      end
   end

   initial begin
      bit g, l;
      logic [7:0] e;
      rst_n = 1'b0; ie = '0; ip = '0; src_flag = '0;
      instr_end = 1'b0; poll_block = 1'b0; int_ack = 1'b0; reti = 1'b0;
      #12;
      check("rst_int_req", 32'(int_req), 32'd0);
      check("rst_vector", 32'(int_vector), 32'd0);
      check("rst_clr", 32'(clr_flag), 32'd0);
      check("rst_in_service", 32'(in_service), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      @(negedge clk); rst_n = 1'b1;
      tick();

      // Single source
      poll(8'h81, 5'h00, 5'b00001, 1'b0, g, l); ack(l, 1'b0);
      reti_pulse();
      // Natural order, then next in line after RETI
      poll(8'h9F, 5'h00, 5'b11010, 1'b0, g, l); ack(l, 1'b0);
      reti_pulse();
      poll(8'h9F, 5'h00, 5'b11000, 1'b0, g, l); ack(l, 1'b0);
      reti_pulse();
      // Priority and nesting
      poll(8'h9F, 5'b10000, 5'b01000, 1'b0, g, l); ack(l, 1'b0);
      poll(8'h9F, 5'b10000, 5'b11000, 1'b0, g, l); ack(l, 1'b0);
      poll(8'h9F, 5'b10000, 5'b00001, 1'b0, g, l); tick();
      reti_pulse(); reti_pulse(); reti_pulse();
      // RETI coincident with ack
      poll(8'h9F, 5'b10000, 5'b00001, 1'b0, g, l); ack(l, 1'b0);
      poll(8'h9F, 5'b10000, 5'b10000, 1'b0, g, l); ack(l, 1'b1);
      reti_pulse();
      // Blocking, EA off, flag dropped in REQ
      poll(8'h9F, 5'h00, 5'b00001, 1'b1, g, l); tick();
      poll(8'h1F, 5'h00, 5'b11111, 1'b0, g, l); tick();
      poll(8'h9F, 5'h00, 5'b00100, 1'b0, g, l);
      src_flag = '0; ie = '0; tick(); tick(); tick();
      ack(l, 1'b0);
      reti_pulse();
      // Reset mid-REQ with a low level in service
      poll(8'h9F, 5'b10000, 5'b00001, 1'b0, g, l); ack(l, 1'b0);
      poll(8'h9F, 5'b10000, 5'b10000, 1'b0, g, l); tick();
      #3 rst_n = 1'b0;
      #1;
      check("async_rst_int_req", 32'(int_req), 32'd0);
      check("async_rst_in_service", 32'(in_service), 32'd0);
      check("async_rst_busy", 32'(busy), 32'd0);
      exp_q.delete(); m_is = 2'b00; m_req = 1'b0; m_busy = 1'b0;
      src_flag = '0; ie = '0;
      @(negedge clk); rst_n = 1'b1;
      repeat (4) tick();

      // Randomized traffic
      for (int n = 0; n < 300; n++) begin
         e = {($urandom_range(0, 9) != 0) ? 1'b1 : 1'b0, 2'b00, 5'($urandom)};
         poll(e, 5'($urandom), 5'($urandom), $urandom_range(0, 9) == 0, g, l);
         if (g) begin
            if ($urandom_range(0, 3) == 0) begin
               src_flag = 5'($urandom); ie = 8'($urandom);
            end
            if ($urandom_range(0, 3) == 0) begin
               src_flag = 5'h1F; ie = 8'h9F; ip = 5'h1F; instr_end = 1'b1;
               tick();
               instr_end = 1'b0;
            end
            repeat ($urandom_range(0, 2)) tick();
            ack(l, $urandom_range(0, 3) == 0);
         end else begin
            tick();
         end
         if ($urandom_range(0, 2) == 0) reti_pulse();
      end

      tick(); tick();
      check("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/int_priority_sequencer.md
Name: int_priority_sequencer

Overview:
- Sequences 8051 interrupt service for the core's five sources: IE0, TF0, IE1, TF1 and serial (RI|TI).
- Polls masked request flags at instruction boundaries and resolves the two IP priority levels plus the fixed natural order.
- Issues a vectored LCALL request to the CPU with a req/ack handshake, tracks two-level nesting, and pulses hardware flag-clear strobes back to the TCON logic.
- Sits between the interrupt flag/mask logic and the CPU control FSM.

Parameters:
- NUM_SRC, 5, number of interrupt sources; index 0 = IE0, 1 = TF0, 2 = IE1, 3 = TF1, 4 = serial.
- VEC_BASE, 16'h0003, vector address of source 0.
- VEC_STRIDE, 8, vector spacing in bytes.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- ie  in  8  IE SFR; bit 7 = EA, bits 4:0 = per-source enables
- ip  in  5  IP SFR bits 4:0; 1 = high priority
- src_flag  in  NUM_SRC  raw request flags {RI|TI, TF1, IE1, TF0, IE0}
- instr_end  in  1  one-cycle pulse on the last cycle of each instruction
- poll_block  in  1  current instruction is RETI or writes IE/IP; valid with instr_end
- int_ack  in  1  CPU has started the LCALL for the presented vector
- reti  in  1  one-cycle pulse when the CPU executes RETI
- int_req  out  1  interrupt request to CPU
- int_vector  out  16  vector address; valid while int_req = 1
- clr_flag  out  NUM_SRC  one-cycle hardware flag-clear strobes
- in_service  out  2  {high active, low active}
- busy  out  1  state != IDLE

Behaviour:
- Reset: state = IDLE; int_req = 0; int_vector = 0; clr_flag = 0; in_service = 2'b00. All outputs are registered.
- A source is pending when src_flag[i] & ie[i] & ie[7].
- Eligibility:
  - in_service[1] set: no source is eligible.
  - in_service[0] set: only pending sources with ip[i] = 1 are eligible.
  - otherwise: every pending source is eligible.
- Selection: a high-level eligible source wins over a low-level one. Within a level, the lowest index wins.
- States:
  - IDLE: on instr_end with poll_block = 0 and at least one eligible source, latch idx and level, then go to REQ. Otherwise stay. Latency: instr_end at cycle N gives int_req = 1 from cycle N+1.
  - REQ: int_req = 1 and int_vector = VEC_BASE + VEC_STRIDE*idx (0003, 000B, 0013, 001B, 0023). Hold until int_ack. The latched request is committed: it is not withdrawn or re-arbitrated if the flag clears, EA drops, or a higher source arrives. On int_ack, set in_service[level], drop int_req the next cycle, and go to CLR.
  - CLR: for one cycle, clr_flag[idx] = 1 if idx <= 3. The serial source is never hardware-cleared. Then go to IDLE.
- reti: clears the highest set in_service bit (bit 1 first, then bit 0). reti with in_service = 0 has no effect.
- reti and int_ack in the same cycle: apply the reti clear to the prior in_service value first, then set the bit for the ack.
- instr_end outside IDLE is ignored; there is no queueing.
- int_ack outside REQ is ignored.
- An asynchronous reset in any state returns immediately to the reset values. No clr_flag pulse is emitted for an in-flight request.

Decomposition:
- Shared package int_pkg:
  - source index constants SRC_IE0..SRC_SER
  - VEC_BASE and VEC_STRIDE
  - state encoding IDLE/REQ/CLR
- Sub-module int_prio_encoder: combinational block taking pending[4:0], ip and in_service; returning valid, idx[2:0] and level.

Test Plan:
- Single source: ie = 8'h81, src_flag = 5'b00001, instr_end pulse -> int_req at +1 with vector 16'h0003. int_ack -> in_service = 2'b01, clr_flag = 5'b00001 for one cycle.
- Natural order: ie = 8'h9F, ip = 0, flags = 5'b11010 -> vector 16'h000B (TF0). After its reti, the next poll gives 16'h001B (TF1).
- Priority and nesting: ie = 8'h9F, ip = 5'b10000.
  - Low TF1 is in service; RI then asserts and instr_end pulses -> vector 16'h0023, in_service = 2'b11, clr_flag = 0.
  - A further low request while in service -> no int_req.
- RETI ordering: from in_service = 2'b11, one reti -> 2'b01, a second reti -> 2'b00, a third reti -> no change. reti coincident with int_ack from 2'b01 on a high request -> 2'b10.
- Blocking and masking: poll_block = 1 with instr_end -> no request. EA = 0 -> no request. Flag dropped while in REQ -> int_req held until ack.
- Reset mid-REQ: rst_n low asynchronously -> int_req = 0 and in_service = 0 before the next clk edge. No clr_flag pulse after release.
